rv_pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core: Q100H fetch, Q101H decode, Q102H execute, Q103H memory, Q104H write-back.
- Owns per-stage valid bits and drives the per-stage ready enables consumed by every stage, including the Q102H execute datapath's ctrl.ready_Q102H.
- Resolves three events: load-use stalls, taken-branch/jump flushes, and data-memory wait states.
- Watches the data-memory wait with a timeout.

---
 rtl/rv_pipe_ctrl.sv | 152 +++++++++++++++
 tb/tb_rv_pipe_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rv_pipe_ctrl.sv
// rv_pipe_ctrl - central sequencer for the 5-stage core
//   Q100H fetch, Q101H decode, Q102H execute, Q103H memory, Q104H write-back.
//
// Owns the per-stage valid bits and drives the stage-advance enables.
// It resolves three pipeline events:
//   mem_stall : a load/store in Q103H is waiting on data memory; the whole pipe freezes
//   take      : a taken branch or jump in Q102H redirects fetch and flushes Q101H/Q102H
//   lu        : a load in Q102H feeds the decode instruction; fetch/decode hold and a
//               bubble goes into Q102H
// Priority is mem_stall > take > lu.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   inst_valid_Q100H            fetched instruction valid
//   rs1/rs2/use_rs1/use_rs2     decode source operands (Q101H)
//   rd/load/branch/jump/
//   branch_cond_met (Q102H)     execute-stage instruction info
//   mem_access/dmem_ack (Q103H) memory-stage access and completion
//   ready_Q100H..ready_Q104H    stage-advance enables (combinational)
//   valid_Q101H..valid_Q104H    registered stage valid bits
//   redirect_Q102H              next PC takes the branch/jump target
//   state                       RUN=0, LU_STALL=1, MEM_WAIT=2
//   mem_timeout_err             sticky; set when the dmem wait reaches MEM_TIMEOUT
//
// Optional feature: define PIPE_CTRL_PERF_EN to add the 32-bit wrapping event counters
// perf_lu_cnt, perf_flush_cnt and perf_memwait_cnt.
module rv_pipe_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_Q100H,
    input  logic [4:0]  rs1_Q101H,
    input  logic [4:0]  rs2_Q101H,
    input  logic        use_rs1_Q101H,
    input  logic        use_rs2_Q101H,
    input  logic [4:0]  rd_Q102H,
    input  logic        load_Q102H,
    input  logic        branch_Q102H,
    input  logic        jump_Q102H,
    input  logic        branch_cond_met_Q102H,
    input  logic        mem_access_Q103H,
    input  logic        dmem_ack_Q103H,
    output logic        ready_Q100H,
    output logic        ready_Q101H,
    output logic        ready_Q102H,
    output logic        ready_Q103H,
    output logic        ready_Q104H,
    output logic        valid_Q101H,
    output logic        valid_Q102H,
    output logic        valid_Q103H,
    output logic        valid_Q104H,
    output logic        redirect_Q102H,
    output logic [1:0]  state,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] perf_lu_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_memwait_cnt,
`endif
    output logic        mem_timeout_err
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t             st;
    logic [TMO_W-1:0]   wait_cnt;
    logic [TMO_W-1:0]   wait_cnt_nxt;
    logic               mem_stall;
    logic               take;
    logic               lu;
    logic               take_go;
    logic               lu_go;

    // Bubbles never raise events: every term is qualified by its stage valid.
    assign mem_stall = valid_Q103H & mem_access_Q103H & ~dmem_ack_Q103H;
    assign take      = valid_Q102H & (jump_Q102H | (branch_Q102H & branch_cond_met_Q102H));
    assign lu        = valid_Q102H & load_Q102H & (rd_Q102H != 5'd0) & valid_Q101H &
                       ((use_rs1_Q101H & (rs1_Q101H == rd_Q102H)) |
                        (use_rs2_Q101H & (rs2_Q101H == rd_Q102H)));

    // Effective events after priority. A taken branch held behind a memory stall
    // only redirects in the cycle the stall releases.
    assign take_go = take & ~mem_stall;
    assign lu_go   = lu & ~mem_stall & ~take;

    assign ready_Q100H    = ~mem_stall & ~lu_go;
    assign ready_Q101H    = ~mem_stall & ~lu_go;
    assign ready_Q102H    = ~mem_stall;
    assign ready_Q103H    = ~mem_stall;
    assign ready_Q104H    = ~mem_stall;
    assign redirect_Q102H = take_go;
    assign state          = st;

    // Wait counter counts stalled memory cycles and saturates at all-ones.
    assign wait_cnt_nxt = (wait_cnt == {TMO_W{1'b1}}) ? wait_cnt : wait_cnt + TMO_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st              <= RUN;
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
            valid_Q101H     <= 1'b0;
            valid_Q102H     <= 1'b0;
            valid_Q103H     <= 1'b0;
            valid_Q104H     <= 1'b0;
        end else if (mem_stall) begin
            // Whole pipe frozen: valid bits hold.
            st       <= MEM_WAIT;
            wait_cnt <= wait_cnt_nxt;
            // The pipe keeps waiting after a timeout; the flag is only a report.
            if (wait_cnt_nxt == TMO_W'(MEM_TIMEOUT))
                mem_timeout_err <= 1'b1;
        end else begin
            wait_cnt    <= '0;
            valid_Q104H <= valid_Q103H;
            valid_Q103H <= valid_Q102H;
            if (take_go) begin
                // Q101H and Q102H hold wrong-path instructions.
                valid_Q102H <= 1'b0;
                valid_Q101H <= 1'b0;
            end else if (lu_go) begin
                // Bubble into Q102H; decode instruction waits one cycle and then
                // picks the load result up through forwarding from Q103H.
                valid_Q102H <= 1'b0;
            end else begin
                valid_Q102H <= valid_Q101H;
                valid_Q101H <= inst_valid_Q100H;
            end
            st <= (lu_go && st == RUN) ? LU_STALL : RUN;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_lu_cnt      <= '0;
            perf_flush_cnt   <= '0;
            perf_memwait_cnt <= '0;
        end else begin
            if (lu_go)     perf_lu_cnt      <= perf_lu_cnt + 32'd1;
            if (take_go)   perf_flush_cnt   <= perf_flush_cnt + 32'd1;
            if (mem_stall) perf_memwait_cnt <= perf_memwait_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Bench for rv_pipe_ctrl: directed scenarios with literal expectations, plus a
// stage-level model checked against the DUT on every falling clock edge.
module tb_rv_pipe_ctrl;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       inst_valid;
    logic [4:0] rs1, rs2, rd;
    logic       use_rs1, use_rs2, load, branch, jump, cond, mem_access, ack;
    logic       r100, r101, r102, r103, r104;
    logic       v101, v102, v103, v104;
    logic       redirect;
    logic [1:0] state;
    logic       err;

    int total = 0;
    int bad   = 0;

    rv_pipe_ctrl #(.MEM_TIMEOUT(TMO), .TMO_W(8)) dut (
        .clk(clk), .rst(rst),
        .inst_valid_Q100H(inst_valid),
        .rs1_Q101H(rs1), .rs2_Q101H(rs2),
        .use_rs1_Q101H(use_rs1), .use_rs2_Q101H(use_rs2),
        .rd_Q102H(rd), .load_Q102H(load), .branch_Q102H(branch), .jump_Q102H(jump),
        .branch_cond_met_Q102H(cond),
        .mem_access_Q103H(mem_access), .dmem_ack_Q103H(ack),
        .ready_Q100H(r100), .ready_Q101H(r101), .ready_Q102H(r102),
        .ready_Q103H(r103), .ready_Q104H(r104),
        .valid_Q101H(v101), .valid_Q102H(v102), .valid_Q103H(v103), .valid_Q104H(v104),
        .redirect_Q102H(redirect), .state(state), .mem_timeout_err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    // mv[n] = expected valid of stage Q10nH (n = 1..4)
    bit [4:1] mv;
    int       ms, mc;
    bit       me;

    always @(negedge clk) begin
        bit       stl, tk, lh;
        bit [4:0] rdy;
        if (!rst) begin
            mv = '0; ms = 0; mc = 0; me = 0;
        end
        stl = mv[3] && mem_access && !ack;
        tk  = mv[2] && (jump || (branch && cond));
        lh  = mv[2] && load && rd != 0 && mv[1] &&
              ((use_rs1 && rs1 == rd) || (use_rs2 && rs2 == rd));
        if (stl)     rdy = 5'b00000;
        else if (tk) rdy = 5'b11111;
        else if (lh) rdy = 5'b11100;
        else         rdy = 5'b11111;
        chk("m_ready", {r104, r103, r102, r101, r100}, rdy);
        chk("m_redirect", redirect, !stl && tk);
        chk("m_valid", {v104, v103, v102, v101}, mv);
        chk("m_state", state, ms);
        chk("m_err", err, me);
        if (rst) begin
            if (stl) begin
                ms = 2;
                if (mc < 255) mc++;
                if (mc == TMO) me = 1;
            end else begin
                mc = 0;
                mv[4] = mv[3];
                mv[3] = mv[2];
                if (tk) begin
                    mv[2] = 0; mv[1] = 0; ms = 0;
                end else if (lh) begin
                    mv[2] = 0; ms = (ms == 0) ? 1 : 0;
                end else begin
                    mv[2] = mv[1]; mv[1] = inst_valid; ms = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        inst_valid = 1; rs1 = 0; rs2 = 0; rd = 0; use_rs1 = 0; use_rs2 = 0;
        load = 0; branch = 0; jump = 0; cond = 0; mem_access = 0; ack = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        inst_valid = 0;
        #2;
        chk("rst_ready", {r104, r103, r102, r101, r100}, 5'b11111);
        chk("rst_valid", {v104, v103, v102, v101}, 4'b0000);
        chk("rst_state", state, 0);
        chk("rst_redirect", redirect, 0);
        step(2);
        rst = 1;
        clr();
        step(4);
        chk("fill_valid", {v104, v103, v102, v101}, 4'b1111);

        // load x5 in Q102H, decode reads rs2 = x5
        load = 1; rd = 5; rs2 = 5; use_rs2 = 1; #1;
        chk("lu_r100", r100, 0);
        chk("lu_r101", r101, 0);
        chk("lu_r102", r102, 1);
        step(1); clr(); #1;
        chk("lu_bubble", v102, 0);
        chk("lu_v101", v101, 1);
        chk("lu_state1", state, 1);
        chk("lu_ready_after", {r104, r103, r102, r101, r100}, 5'b11111);
        step(1);
        chk("lu_state0", state, 0);
        step(3);

        // load rd = x0 never hazards
        load = 1; rd = 0; rs1 = 0; use_rs1 = 1; #1;
        chk("x0_ready", {r104, r103, r102, r101, r100}, 5'b11111);
        step(1); clr(); #1;
        chk("x0_state", state, 0);
        chk("x0_v102", v102, 1);
        step(2);

        // taken BEQ with a load-use also present
        branch = 1; cond = 1; load = 1; rd = 7; rs1 = 7; use_rs1 = 1; #1;
        chk("br_redirect", redirect, 1);
        chk("br_r100", r100, 1);
        step(1); clr(); #1;
        chk("br_flush", {v102, v101}, 2'b00);
        chk("br_v103", v103, 1);
        chk("br_state", state, 0);
        chk("br_redirect_off", redirect, 0);
        step(4);

        // store waiting 3 cycles while a jump sits in Q102H
        jump = 1; mem_access = 1; ack = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("mw_ready", {r104, r103, r102, r101, r100}, 5'b00000);
            chk("mw_redirect", redirect, 0);
            chk("mw_state", state, (k == 0) ? 0 : 2);
            step(1);
        end
        ack = 1; #1;
        chk("mw_rel_redirect", redirect, 1);
        chk("mw_rel_state", state, 2);
        chk("mw_rel_ready", r100, 1);
        step(1); clr(); #1;
        chk("mw_after_state", state, 0);
        chk("mw_after_v102", v102, 0);
        step(4);

        // timeout: ack low for 10 cycles with MEM_TIMEOUT = 4
        mem_access = 1; ack = 0;
        for (int k = 1; k <= 10; k++) begin
            #1;
            chk("tmo_err", err, (k >= 5) ? 1 : 0);
            step(1);
        end
        ack = 1;
        step(1); clr(); #1;
        chk("tmo_sticky", err, 1);
        step(4);

        // reset in the middle of a memory wait with counter = 3
        jump = 1; mem_access = 1; ack = 0;
        step(3);
        chk("rs_cnt3", dut.wait_cnt, 3);
        chk("rs_state_pre", state, 2);
        rst = 0; #1;
        chk("rs_valid", {v104, v103, v102, v101}, 4'b0000);
        chk("rs_state", state, 0);
        chk("rs_cnt", dut.wait_cnt, 0);
        chk("rs_err", err, 0);
        chk("rs_redirect", redirect, 0);
        step(1);
        rst = 1; clr();
        step(3);
        chk("rs_refill", {v103, v102, v101}, 3'b111);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
